csa_share_ctrl: RTL and testbench
=================================

Name: csa_share_ctrl

Overview:
- Shares one external 4-bit carry-select adder (combinational; ports A, B, Cin, S, Cout) between two requesters.
- Each request is a WIDTH-bit add of a + b + cin, executed nibble-serially, LSB nibble first, with Cout chained into the next Cin.
- Round-robin arbitration between the two requesters, valid/ready on the request side, and a one-cycle response pulse per requester.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; NNIB = WIDTH/4.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 accepted on valid&&ready
- req0_a  input  WIDTH  operand A
- req0_b  input  WIDTH  operand B
- req0_cin  input  1  carry in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- rsp0_valid  output  1  one-cycle completion pulse for requester 0
- rsp0_sum  output  WIDTH  result
- rsp0_cout  output  1  final carry
- rsp1_valid, rsp1_sum, rsp1_cout  same as response 0, for requester 1
- csa_a  output  4  nibble to adder A
- csa_b  output  4  nibble to adder B
- csa_cin  output  1  carry to adder Cin
- csa_s  input  4  adder S
- csa_cout  input  1  adder Cout

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk.
- Reset values:
  - State IDLE; all rsp*_valid = 0; rsp*_sum = 0; rsp*_cout = 0.
  - csa_a = 0, csa_b = 0, csa_cin = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant is combinational: the sole valid requester wins; if both are valid, the one != last_grant wins.
  - reqX_ready = 1 only for the granted requester, and only in IDLE. Both ready = 0 if neither is valid.
  - On valid&&ready: latch a, b and cin, record the owner, set last_grant = owner, set idx = 0, carry = cin, and go to RUN.
- RUN:
  - Drive csa_a = a_reg[4*idx+:4], csa_b = b_reg[4*idx+:4], csa_cin = carry.
  - Each edge: sum_reg[4*idx+:4] <= csa_s; carry <= csa_cout; idx++.
  - After the NNIB-th capture, go to DONE.
- DONE:
  - Owner's rspX_sum <= sum_reg and rspX_cout <= carry; rspX_valid = 1 for exactly one cycle. Then return to IDLE.
- Outside RUN, csa_a, csa_b and csa_cin are driven to 0.
- Latency: the accepting edge is cycle 0; rspX_valid is high in cycle NNIB+1.
- Occupancy per operation: NNIB+2 cycles; no new acceptance before the return to IDLE.
- Response values persist after the pulse until that requester's next completion. The other requester's response registers are never modified.
- Responses have no backpressure. Requesters must hold valid and operands stable until accepted. Inputs are ignored while busy.
- Arithmetic: result is the exact (WIDTH+1)-bit a + b + cin, with the MSB in cout. Wrap-around of sum is modulo 2^WIDTH.
- Reset mid-operation: the operation is abandoned and no rsp pulse is produced. The bench sees IDLE values on the cycle after the reset edge.
- Simultaneous events: a new request that arrives while busy waits. When both are waiting at return to IDLE, the one not served last wins.

Test Plan:
- WIDTH=16; req0 a=0x1234, b=0x4321, cin=0 -> rsp0_valid exactly 5 cycles after the accept edge, rsp0_sum=0x5555, rsp0_cout=0; rsp1_valid stays 0.
- req0 a=0xFFFF, b=0x0000, cin=1 -> full carry ripple across 4 nibbles: rsp0_sum=0x0000, rsp0_cout=1. Bench checks csa_cin = 1 in every RUN cycle.
- Both valid on the first cycle after reset; req0 a=0x0001, b=0x0001; req1 a=0x8000, b=0x8000 -> req0 granted first (sum 0x0002, cout 0). Then req1: sum 0x0000, cout 1. req1_ready = 0 throughout req0's operation.
- Both valid continuously for 4 operations -> grants alternate 0,1,0,1; acceptances spaced exactly 6 cycles apart; each response matches its own operands.
- Assert rst_n=0 during the 2nd RUN cycle of a req1 operation -> no rsp1_valid pulse; all outputs at reset values; a subsequent req1 completes correctly.
- WIDTH=8; req1 a=0xF0, b=0x10, cin=0 -> rsp1_valid 3 cycles after accept, rsp1_sum=0x00, rsp1_cout=1.

Source files
------------

// File: rtl/csa_share_ctrl.sv
// -----------------------------------------------------------------------------
// csa_share_ctrl
//
// Shares one external combinational 4-bit carry-select adder between two
// requesters. Each request is a WIDTH-bit a + b + cin. It is executed one
// nibble per cycle, least significant nibble first, with the adder carry-out
// chained into the next carry-in. Requesters are served round-robin.
//
// Timing: the accepting edge is cycle 0. Nibbles are captured on edges
// 1..NNIB, and the response pulse is visible in cycle NNIB+1. Each operation
// occupies the block for NNIB+2 cycles.
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   reqX_valid / reqX_ready    request handshake, accepted on valid && ready
//   reqX_a, reqX_b, reqX_cin   operands; held stable by the requester until accepted
//   rspX_valid                 one-cycle completion pulse for requester X
//   rspX_sum, rspX_cout        result; held until that requester's next completion
//   csa_a, csa_b, csa_cin      nibble operands driven to the external adder
//                              (zero outside RUN)
//   csa_s, csa_cout            sum and carry returned by the external adder
// -----------------------------------------------------------------------------
module csa_share_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,

    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_cout,

    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_cout,

    output logic [3:0]       csa_a,
    output logic [3:0]       csa_b,
    output logic             csa_cin,
    input  logic [3:0]       csa_s,
    input  logic             csa_cout
);

    localparam int NNIB  = WIDTH / 4;
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Arbitration and sequencing state
    logic             r_last_grant;   // requester served most recently
    logic             r_owner;        // requester owning the current operation
    logic [IDX_W-1:0] r_idx;          // nibble being processed in RUN
    logic             r_carry;        // carry chained between nibbles

    // Operand and partial-result storage
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;

    // Response registers
    logic             r_rsp0_valid;
    logic [WIDTH-1:0] r_rsp0_sum;
    logic             r_rsp0_cout;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp1_sum;
    logic             r_rsp1_cout;

    logic             w_idle;
    logic             w_any_valid;
    logic             w_grant;        // 0: requester 0 wins, 1: requester 1 wins
    logic             w_accept;
    logic             w_last_nib;

    // -------------------------------------------------------------------------
    // Arbitration: a sole valid requester wins outright; under contention the
    // requester that was not served last wins.
    // -------------------------------------------------------------------------
    assign w_idle      = (r_state == ST_IDLE);
    assign w_any_valid = req0_valid | req1_valid;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
    end

    assign req0_ready = w_idle & w_any_valid & ~w_grant;
    assign req1_ready = w_idle & w_any_valid &  w_grant;

    // Whenever IDLE sees any valid request, exactly one ready is high, so the
    // handshake completes for the granted requester.
    assign w_accept   = w_idle & w_any_valid;
    assign w_last_nib = (r_idx == LAST_IDX);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_nib) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Adder drive: the current nibble pair and chained carry while in RUN,
    // zero otherwise.
    // -------------------------------------------------------------------------
    always_comb begin
        csa_a   = 4'h0;
        csa_b   = 4'h0;
        csa_cin = 1'b0;
        if (r_state == ST_RUN) begin
            csa_a   = r_a[4*r_idx +: 4];
            csa_b   = r_b[4*r_idx +: 4];
            csa_cin = r_carry;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;    // requester 0 wins the first contention
            r_owner      <= 1'b0;
            r_idx        <= '0;
            r_carry      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_idx        <= '0;
                        r_carry      <= w_grant ? req1_cin : req0_cin;
                    end
                end
                ST_RUN: begin
                    r_carry <= csa_cout;
                    r_idx   <= w_last_nib ? '0 : r_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Operand and partial-sum storage
    // -------------------------------------------------------------------------
    // NOTE: these registers have no reset. They are always loaded before
    // they are read: operands on acceptance, every sum nibble during RUN.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= w_grant ? req1_a : req0_a;
            r_b <= w_grant ? req1_b : req0_b;
        end
        if (r_state == ST_RUN) begin
            r_sum[4*r_idx +: 4] <= csa_s;
        end
    end

    // -------------------------------------------------------------------------
    // Response registers. Only the owner's result is written, and the pulse
    // lasts exactly the one cycle after DONE. Reset mid-operation returns to
    // IDLE without passing through DONE, so no pulse is produced.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_sum   <= '0;
            r_rsp0_cout  <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_sum   <= '0;
            r_rsp1_cout  <= 1'b0;
        end else begin
            r_rsp0_valid <= (r_state == ST_DONE) && !r_owner;
            r_rsp1_valid <= (r_state == ST_DONE) &&  r_owner;
            if (r_state == ST_DONE) begin
                if (r_owner) begin
                    r_rsp1_sum  <= r_sum;
                    r_rsp1_cout <= r_carry;
                end else begin
                    r_rsp0_sum  <= r_sum;
                    r_rsp0_cout <= r_carry;
                end
            end
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_sum   = r_rsp0_sum;
    assign rsp0_cout  = r_rsp0_cout;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_sum   = r_rsp1_sum;
    assign rsp1_cout  = r_rsp1_cout;

endmodule

// File: tb/tb_csa_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_csa_share_ctrl
//
// Directed bench for csa_share_ctrl. A 16-bit instance and an 8-bit instance
// are each paired with a behavioural 4-bit adder. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_csa_share_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- 16-bit instance ----------------
    logic        r0v, r1v, r0c, r1c;
    logic [15:0] r0a, r0b, r1a, r1b;
    logic        rdy0, rdy1;
    logic        s0v, s1v, s0c, s1c;
    logic [15:0] s0sum, s1sum;
    logic [3:0]  ca, cb, cs;
    logic        ccin, ccout;

    assign {ccout, cs} = 5'(ca) + 5'(cb) + 5'(ccin);

    csa_share_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(rdy0), .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
        .req1_valid(r1v), .req1_ready(rdy1), .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
        .rsp0_valid(s0v), .rsp0_sum(s0sum), .rsp0_cout(s0c),
        .rsp1_valid(s1v), .rsp1_sum(s1sum), .rsp1_cout(s1c),
        .csa_a(ca), .csa_b(cb), .csa_cin(ccin), .csa_s(cs), .csa_cout(ccout)
    );

    // ---------------- 8-bit instance ----------------
    logic       q0v, q1v, q0c, q1c;
    logic [7:0] q0a, q0b, q1a, q1b;
    logic       qrdy0, qrdy1;
    logic       t0v, t1v, t0c, t1c;
    logic [7:0] t0sum, t1sum;
    logic [3:0] da, db, ds;
    logic       dcin, dcout;

    assign {dcout, ds} = 5'(da) + 5'(db) + 5'(dcin);

    csa_share_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(q0v), .req0_ready(qrdy0), .req0_a(q0a), .req0_b(q0b), .req0_cin(q0c),
        .req1_valid(q1v), .req1_ready(qrdy1), .req1_a(q1a), .req1_b(q1b), .req1_cin(q1c),
        .rsp0_valid(t0v), .rsp0_sum(t0sum), .rsp0_cout(t0c),
        .rsp1_valid(t1v), .rsp1_sum(t1sum), .rsp1_cout(t1c),
        .csa_a(da), .csa_b(db), .csa_cin(dcin), .csa_s(ds), .csa_cout(dcout)
    );

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation on the 16-bit instance for requester 'who'.
    // exp_cins holds the expected csa_cin for RUN cycles 0..3.
    task automatic do_op(input bit who, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] exp_sum,
                         input logic exp_cout, input logic [3:0] exp_cins);
        int n;
        logic [15:0] other_sum;
        other_sum = who ? s0sum : s1sum;
        if (who) begin r1v = 1'b1; r1a = a; r1b = b; r1c = cin; end
        else     begin r0v = 1'b1; r0a = a; r0b = b; r0c = cin; end
        #1;
        n = 0;
        while (!(who ? rdy1 : rdy0) && n < 20) begin
            tick();
            n++;
        end
        check("op_accept_in_time", 32'(n < 20), 32'd1);
        tick();                                   // accepting edge, cycle 0
        r0v = 1'b0;
        r1v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("op_run_csa_cin", 32'(ccin), 32'(exp_cins[i]));
            check("op_no_early_rsp", 32'(who ? s1v : s0v), 32'd0);
            check("op_other_rsp_quiet", 32'(who ? s0v : s1v), 32'd0);
            tick();
        end
        check("op_done_no_rsp_yet", 32'(who ? s1v : s0v), 32'd0);
        tick();                                   // cycle NNIB+1 = 5
        check("op_rsp_valid", 32'(who ? s1v : s0v), 32'd1);
        check("op_rsp_sum", 32'(who ? s1sum : s0sum), 32'(exp_sum));
        check("op_rsp_cout", 32'(who ? s1c : s0c), 32'(exp_cout));
        check("op_other_valid", 32'(who ? s0v : s1v), 32'd0);
        check("op_other_sum_kept", 32'(who ? s0sum : s1sum), 32'(other_sum));
        check("op_idle_csa_zero", 32'({ca, cb, ccin}), 32'd0);
        tick();
        check("op_rsp_one_cycle", 32'(who ? s1v : s0v), 32'd0);
        check("op_rsp_sum_held", 32'(who ? s1sum : s0sum), 32'(exp_sum));
    endtask

    // Two operations per requester for the back-to-back round-robin test.
    logic [15:0] t4_a0[2]   = '{16'h1111, 16'hA000};
    logic [15:0] t4_b0[2]   = '{16'h2222, 16'h7000};
    logic        t4_c0[2]   = '{1'b0, 1'b1};
    logic [15:0] t4_s0[2]   = '{16'h3333, 16'h1001};
    logic        t4_co0[2]  = '{1'b0, 1'b1};
    logic [15:0] t4_a1[2]   = '{16'h0F0F, 16'hFFFF};
    logic [15:0] t4_b1[2]   = '{16'h00F1, 16'hFFFF};
    logic        t4_c1[2]   = '{1'b0, 1'b1};
    logic [15:0] t4_s1[2]   = '{16'h1000, 16'hFFFF};
    logic        t4_co1[2]  = '{1'b0, 1'b1};

    initial begin
        int n0, n1, r0n, r1n, nacc;
        int acc_cyc[4];
        int acc_who[4];
        int acc0_cyc[2];
        int acc1_cyc[2];
        int who;

        rst_n = 1'b0;
        r0v = 1'b0; r0a = '0; r0b = '0; r0c = 1'b0;
        r1v = 1'b0; r1a = '0; r1b = '0; r1c = 1'b0;
        q0v = 1'b0; q0a = '0; q0b = '0; q0c = 1'b0;
        q1v = 1'b0; q1a = '0; q1b = '0; q1c = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        check("rst_rsp0_valid", 32'(s0v), 32'd0);
        check("rst_rsp1_valid", 32'(s1v), 32'd0);
        check("rst_rsp0_sum", 32'(s0sum), 32'd0);
        check("rst_rsp1_sum", 32'(s1sum), 32'd0);
        check("rst_couts", 32'({s0c, s1c}), 32'd0);
        check("rst_csa_zero", 32'({ca, cb, ccin}), 32'd0);
        check("rst_ready_no_valid", 32'({rdy0, rdy1}), 32'd0);

        // ---- contention on the first cycle after reset ----
        rst_n = 1'b1;
        r0v = 1'b1; r0a = 16'h0001; r0b = 16'h0001; r0c = 1'b0;
        r1v = 1'b1; r1a = 16'h8000; r1b = 16'h8000; r1c = 1'b0;
        #1;
        check("t3_ready0_first", 32'(rdy0), 32'd1);
        check("t3_ready1_blocked", 32'(rdy1), 32'd0);
        tick();                                   // req0 accepted
        r0v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3_ready1_low_busy", 32'(rdy1), 32'd0);
            tick();
        end
        check("t3_rsp0_valid", 32'(s0v), 32'd1);
        check("t3_rsp0_sum", 32'(s0sum), 32'h0002);
        check("t3_rsp0_cout", 32'(s0c), 32'd0);
        check("t3_ready1_now", 32'(rdy1), 32'd1);
        tick();                                   // req1 accepted
        r1v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t3_rsp1_not_yet", 32'(s1v), 32'd0);
            tick();
        end
        tick();
        check("t3_rsp1_valid", 32'(s1v), 32'd1);
        check("t3_rsp1_sum", 32'(s1sum), 32'h0000);
        check("t3_rsp1_cout", 32'(s1c), 32'd1);
        check("t3_rsp0_sum_held", 32'(s0sum), 32'h0002);
        tick();

        // ---- simple add, no carries ----
        do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000);

        // ---- full carry ripple ----
        do_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'b1111);

        // ---- reset during the 2nd RUN cycle of a req1 operation ----
        r1v = 1'b1; r1a = 16'h0123; r1b = 16'h0456; r1c = 1'b0;
        #1;
        check("t5_ready1", 32'(rdy1), 32'd1);
        tick();                                   // accepted; RUN cycle 1
        r1v = 1'b0;
        tick();                                   // RUN cycle 2
        rst_n = 1'b0;
        tick();
        check("t5_rst_rsp1_valid", 32'(s1v), 32'd0);
        check("t5_rst_rsp0_valid", 32'(s0v), 32'd0);
        check("t5_rst_sums", 32'({s0sum, s1sum}), 32'd0);
        check("t5_rst_couts", 32'({s0c, s1c}), 32'd0);
        check("t5_rst_csa_zero", 32'({ca, cb, ccin}), 32'd0);
        check("t5_rst_ready", 32'({rdy0, rdy1}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t5_no_rsp1_pulse", 32'(s1v), 32'd0);
        end
        do_op(1'b1, 16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0, 4'b0000);

        // ---- both valid continuously for 4 operations ----
        n0 = 0; n1 = 0; r0n = 0; r1n = 0; nacc = 0;
        for (int i = 0; i < 4; i++) begin acc_cyc[i] = 0; acc_who[i] = 0; end
        acc0_cyc[0] = 0; acc0_cyc[1] = 0; acc1_cyc[0] = 0; acc1_cyc[1] = 0;
        r0v = 1'b1; r0a = t4_a0[0]; r0b = t4_b0[0]; r0c = t4_c0[0];
        r1v = 1'b1; r1a = t4_a1[0]; r1b = t4_b1[0]; r1c = t4_c1[0];
        for (int c = 0; c < 60 && (r0n + r1n) < 4; c++) begin
            #1;
            check("t4_ready_exclusive", 32'(rdy0 & rdy1), 32'd0);
            who = rdy0 ? 0 : (rdy1 ? 1 : -1);
            tick();
            if (who >= 0 && nacc < 4) begin
                acc_cyc[nacc] = c;
                acc_who[nacc] = who;
                nacc++;
            end
            if (who == 0 && n0 < 2) begin
                acc0_cyc[n0] = c;
                n0++;
                if (n0 < 2) begin r0a = t4_a0[n0]; r0b = t4_b0[n0]; r0c = t4_c0[n0]; end
                else r0v = 1'b0;
            end
            if (who == 1 && n1 < 2) begin
                acc1_cyc[n1] = c;
                n1++;
                if (n1 < 2) begin r1a = t4_a1[n1]; r1b = t4_b1[n1]; r1c = t4_c1[n1]; end
                else r1v = 1'b0;
            end
            if (s0v) begin
                if (r0n < 2) begin
                    check("t4_rsp0_sum", 32'(s0sum), 32'(t4_s0[r0n]));
                    check("t4_rsp0_cout", 32'(s0c), 32'(t4_co0[r0n]));
                    check("t4_rsp0_latency", 32'(c), 32'(acc0_cyc[r0n] + 5));
                end else begin
                    check("t4_extra_rsp0", 32'(s0v), 32'd0);
                end
                r0n++;
            end
            if (s1v) begin
                if (r1n < 2) begin
                    check("t4_rsp1_sum", 32'(s1sum), 32'(t4_s1[r1n]));
                    check("t4_rsp1_cout", 32'(s1c), 32'(t4_co1[r1n]));
                    check("t4_rsp1_latency", 32'(c), 32'(acc1_cyc[r1n] + 5));
                end else begin
                    check("t4_extra_rsp1", 32'(s1v), 32'd0);
                end
                r1n++;
            end
        end
        r0v = 1'b0;
        r1v = 1'b0;
        check("t4_responses", 32'(r0n + r1n), 32'd4);
        check("t4_acceptances", 32'(nacc), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t4_grant_order", 32'(acc_who[i]), 32'(i % 2));
        end
        for (int i = 1; i < 4; i++) begin
            check("t4_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd6);
        end
        tick();

        // ---- 8-bit instance: carry out of the top nibble ----
        q1v = 1'b1; q1a = 8'hF0; q1b = 8'h10; q1c = 1'b0;
        #1;
        check("w8_ready1", 32'(qrdy1), 32'd1);
        tick();                                   // accepting edge, cycle 0
        q1v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("w8_rsp1_not_yet", 32'(t1v), 32'd0);
            tick();
        end
        check("w8_rsp1_valid", 32'(t1v), 32'd1);
        check("w8_rsp1_sum", 32'(t1sum), 32'h00);
        check("w8_rsp1_cout", 32'(t1c), 32'd1);
        check("w8_rsp0_quiet", 32'(t0v), 32'd0);
        tick();
        check("w8_rsp1_one_cycle", 32'(t1v), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
